// File: rtl/serializador_paralelo_serial_if.sv
// Purpose: handshake/stream bundle between the upstream word source, the
//          parallel-to-serial converter and the serial shift register.
// Signals:
//   dado_in      parallel word offered by the source
//   valido_in    source offers dado_in this cycle
//   pronto_out   converter can take a word this cycle
//   saida        serial bit towards the shift register input
//   saida_valida saida carries a data bit this cycle
//   fim_palavra  single-cycle pulse on the last bit of each word
// Modports: master = word source / stream consumer side, slave = converter.
interface serializador_paralelo_serial_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] dado_in;
    logic             valido_in;
    logic             pronto_out;
    logic             saida;
    logic             saida_valida;
    logic             fim_palavra;

    modport master (
        output dado_in,
        output valido_in,
        input  pronto_out,
        input  saida,
        input  saida_valida,
        input  fim_palavra
    );

    modport slave (
        input  dado_in,
        input  valido_in,
        output pronto_out,
        output saida,
        output saida_valida,
        output fim_palavra
    );
endinterface

// File: rtl/serializador_paralelo_serial.sv
// Purpose: converts parallel words into a serial bit stream for the serial
//          input of the downstream shift register. A one-word holding buffer
//          lets words follow each other without bubbles; GAP idle cycles can
//          be inserted after every word.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    slave side of serializador_paralelo_serial_if (dado_in,
//          valido_in in; pronto_out, saida, saida_valida, fim_palavra out)
// The interface instance must be built with the same WIDTH as this module.
module serializador_paralelo_serial #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1,
    parameter int GAP       = 0
) (
    input  logic                              clock,
    input  logic                              reset,
    serializador_paralelo_serial_if.slave     bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [3:0]    GAP_LAST = 4'(GAP - 1);

    typedef enum logic [1:0] {OCIOSO, DESLOCA, PAUSA} estado_t;

    estado_t          state, state_next;
    logic [WIDTH-1:0] shifter, shifter_next;
    logic [WIDTH-1:0] buffer, buffer_next;
    logic             buffer_cheio, cheio_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [3:0]       gap_cnt, gap_next;
    logic             saida_r, saida_next;
    logic             valida_r, valida_next;
    logic             fim_r, fim_next;
    logic             accept;
    logic             do_load;
    logic [WIDTH-1:0] load_word;

    // Ready depends only on registered state, never on valido_in.
    assign accept         = bus.valido_in && !buffer_cheio;
    assign bus.pronto_out = !buffer_cheio;
    assign bus.saida        = saida_r;
    assign bus.saida_valida = valida_r;
    assign bus.fim_palavra  = fim_r;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= OCIOSO;
            shifter      <= '0;
            buffer       <= '0;
            buffer_cheio <= 1'b0;
            cnt          <= '0;
            gap_cnt      <= '0;
            saida_r      <= 1'b0;
            valida_r     <= 1'b0;
            fim_r        <= 1'b0;
        end else begin
            state        <= state_next;
            shifter      <= shifter_next;
            buffer       <= buffer_next;
            buffer_cheio <= cheio_next;
            cnt          <= cnt_next;
            gap_cnt      <= gap_next;
            saida_r      <= saida_next;
            valida_r     <= valida_next;
            fim_r        <= fim_next;
        end
    end

    always_comb begin
        state_next   = state;
        shifter_next = shifter;
        buffer_next  = buffer;
        cheio_next   = buffer_cheio;
        cnt_next     = cnt;
        gap_next     = gap_cnt;
        saida_next   = saida_r;
        valida_next  = valida_r;
        do_load      = 1'b0;
        load_word    = bus.dado_in;

        case (state)
            OCIOSO: begin
                if (accept) begin
                    do_load = 1'b1;
                end
            end
            DESLOCA: begin
                if (cnt == LAST_BIT) begin
                    if (GAP > 0) begin
                        state_next  = PAUSA;
                        saida_next  = 1'b0;
                        valida_next = 1'b0;
                        gap_next    = '0;
                    end else if (buffer_cheio) begin
                        do_load    = 1'b1;
                        load_word  = buffer;
                        cheio_next = 1'b0;
                    end else if (accept) begin
                        do_load = 1'b1;
                    end else begin
                        state_next  = OCIOSO;
                        saida_next  = 1'b0;
                        valida_next = 1'b0;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                    if (MSB_FIRST != 0) begin
                        shifter_next = shifter << 1;
                        saida_next   = shifter[WIDTH-2];
                    end else begin
                        shifter_next = shifter >> 1;
                        saida_next   = shifter[1];
                    end
                end
            end
            PAUSA: begin
                if (gap_cnt == GAP_LAST) begin
                    if (buffer_cheio) begin
                        do_load    = 1'b1;
                        load_word  = buffer;
                        cheio_next = 1'b0;
                    end else if (accept) begin
                        do_load = 1'b1;
                    end else begin
                        state_next = OCIOSO;
                    end
                end else begin
                    gap_next = gap_cnt + 1'b1;
                end
            end
            default: begin
                state_next  = OCIOSO;
                saida_next  = 1'b0;
                valida_next = 1'b0;
            end
        endcase

        // A word accepted while the shifter is busy waits in the buffer.
        if (accept && !do_load) begin
            buffer_next = bus.dado_in;
            cheio_next  = 1'b1;
        end

        // The shifter keeps the whole word; saida already carries the bit
        // that leaves first, so later shifts expose the next one.
        if (do_load) begin
            state_next   = DESLOCA;
            shifter_next = load_word;
            cnt_next     = '0;
            valida_next  = 1'b1;
            saida_next   = (MSB_FIRST != 0) ? load_word[WIDTH-1] : load_word[0];
        end

        fim_next = (state_next == DESLOCA) && (cnt_next == LAST_BIT);
    end
endmodule

// File: tb/tb_serializador_paralelo_serial.sv
// Purpose: randomized self-checking bench for serializador_paralelo_serial.
// Three instances with different WIDTH / MSB_FIRST / GAP run in parallel
// against a stream-level reference model: each accepted word becomes a list
// of output slots (bits plus trailing idle cycles) appended to a queue that
// is consumed one slot per clock.
module tb_serializador_paralelo_serial;
    typedef struct packed {
        logic valid;
        logic data;
        logic fim;
        logic first;
    } slot_t;

    localparam int NDUT = 3;
    localparam int NCYC = 450;
    localparam int CFG_W   [NDUT] = '{4, 4, 5};
    localparam int CFG_MSB [NDUT] = '{1, 1, 0};
    localparam int CFG_GAP [NDUT] = '{0, 2, 1};

    logic clock;
    logic reset;
    logic [7:0] dado [NDUT];
    logic       valido [NDUT];
    logic       obs_pronto [NDUT];
    logic       obs_saida [NDUT];
    logic       obs_valida [NDUT];
    logic       obs_fim [NDUT];

    slot_t q [NDUT][$];
    int    pending [NDUT];
    slot_t cur [NDUT];
    logic  accept [NDUT];
    int    tests;
    int    fails;

    serializador_paralelo_serial_if #(.WIDTH(4)) bus0 ();
    serializador_paralelo_serial_if #(.WIDTH(4)) bus1 ();
    serializador_paralelo_serial_if #(.WIDTH(5)) bus2 ();

    serializador_paralelo_serial #(.WIDTH(4), .MSB_FIRST(1), .GAP(0)) dut0 (
        .clock(clock), .reset(reset), .bus(bus0.slave));
    serializador_paralelo_serial #(.WIDTH(4), .MSB_FIRST(1), .GAP(2)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1.slave));
    serializador_paralelo_serial #(.WIDTH(5), .MSB_FIRST(0), .GAP(1)) dut2 (
        .clock(clock), .reset(reset), .bus(bus2.slave));

    assign bus0.dado_in   = dado[0][3:0];
    assign bus0.valido_in = valido[0];
    assign bus1.dado_in   = dado[1][3:0];
    assign bus1.valido_in = valido[1];
    assign bus2.dado_in   = dado[2][4:0];
    assign bus2.valido_in = valido[2];

    assign obs_pronto[0] = bus0.pronto_out;
    assign obs_saida[0]  = bus0.saida;
    assign obs_valida[0] = bus0.saida_valida;
    assign obs_fim[0]    = bus0.fim_palavra;
    assign obs_pronto[1] = bus1.pronto_out;
    assign obs_saida[1]  = bus1.saida;
    assign obs_valida[1] = bus1.saida_valida;
    assign obs_fim[1]    = bus1.fim_palavra;
    assign obs_pronto[2] = bus2.pronto_out;
    assign obs_saida[2]  = bus2.saida;
    assign obs_valida[2] = bus2.saida_valida;
    assign obs_fim[2]    = bus2.fim_palavra;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Appends the slots of one accepted word: its bits in transmission order
    // followed by the configured idle cycles.
    task automatic pushWord(input int d, input logic [7:0] word);
        slot_t s;
        int    idx;
        for (int k = 0; k < CFG_W[d]; k++) begin
            idx     = (CFG_MSB[d] != 0) ? (CFG_W[d] - 1 - k) : k;
            s.valid = 1'b1;
            s.data  = word[idx];
            s.fim   = (k == CFG_W[d] - 1);
            s.first = (k == 0);
            q[d].push_back(s);
        end
        for (int g = 0; g < CFG_GAP[d]; g++) begin
            s = '0;
            q[d].push_back(s);
        end
        pending[d]++;
    endtask

    task automatic clearModel();
        for (int d = 0; d < NDUT; d++) begin
            q[d].delete();
            pending[d] = 0;
            cur[d]     = '0;
        end
    endtask

    task automatic advanceModel();
        slot_t s;
        for (int d = 0; d < NDUT; d++) begin
            if (accept[d]) pushWord(d, dado[d]);
            s = '0;
            if (q[d].size() > 0) begin
                s = q[d].pop_front();
                if (s.first) pending[d]--;
            end
            cur[d] = s;
        end
    endtask

    task automatic checkAll(input string phase);
        for (int d = 0; d < NDUT; d++) begin
            checkOutput($sformatf("%s d%0d pronto_out", phase, d), 32'(obs_pronto[d]), 32'(pending[d] == 0));
            checkOutput($sformatf("%s d%0d saida", phase, d), 32'(obs_saida[d]), 32'(cur[d].data));
            checkOutput($sformatf("%s d%0d saida_valida", phase, d), 32'(obs_valida[d]), 32'(cur[d].valid));
            checkOutput($sformatf("%s d%0d fim_palavra", phase, d), 32'(obs_fim[d]), 32'(cur[d].fim));
        end
    endtask

    // Directed opening (two back-to-back words, then a word held while the
    // block is not ready), random traffic afterwards.
    task automatic applyStimulus(input int cyc);
        for (int d = 0; d < NDUT; d++) begin
            if (cyc == 0) begin
                valido[d] = 1'b1;
                dado[d]   = (d == 2) ? 8'h01 : 8'h0B;
            end else if (cyc == 1) begin
                valido[d] = 1'b1;
                dado[d]   = (d == 2) ? 8'h15 : 8'h06;
            end else if (cyc <= 4) begin
                valido[d] = 1'b1;
                dado[d]   = 8'h0F;
            end else if (cyc <= 12) begin
                valido[d] = 1'b0;
                dado[d]   = 8'h00;
            end else begin
                valido[d] = ($urandom_range(0, 99) < 55);
                dado[d]   = 8'($urandom);
            end
            accept[d] = valido[d] && (pending[d] == 0);
        end
    endtask

    // Reset asserted between edges: outputs must clear without a clock edge
    // and stay cleared across an edge while reset is held.
    task automatic pulseReset();
        #2;
        reset = 1'b0;
        for (int d = 0; d < NDUT; d++) valido[d] = 1'b0;
        #1;
        clearModel();
        checkAll("async_reset");
        @(posedge clock);
        #1;
        checkAll("held_reset");
        reset = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            valido[d] = 1'b0;
            dado[d]   = 8'h00;
            accept[d] = 1'b0;
        end
        clearModel();
        repeat (2) @(posedge clock);
        #1;
        checkAll("reset");
        reset = 1'b1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            if (cyc == 160 || cyc == 163 || cyc == 320) pulseReset();
            applyStimulus(cyc);
            @(posedge clock);
            #1;
            advanceModel();
            checkAll("run");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
